// File: rtl/kernel_fetch.sv
// rtl/kernel_fetch.sv - fetches one 3x3 kernel (nine words) from a registered filter ROM
// Address is registered and the ROM is registered, so word k lands in its slot two edges after issue.
module kernel_fetch #(
  parameter int DW          = 8,
  parameter int AW          = 9,
  parameter int NUM_KERNELS = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      kernel_idx,
  output logic [AW-1:0]   rom_addr,
  input  logic [DW-1:0]   rom_data,
  output logic            busy,
  output logic [9*DW-1:0] weights,
  output logic            w_valid,
  input  logic            w_ready,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_ext;
  logic [AW-1:0] base_calc;
  logic [3:0]    slot;

  always_comb begin
    idx_ext   = AW'(kernel_idx);
    base_calc = (idx_ext << 3) + idx_ext;
    slot      = cnt - 4'd1;
  end

  // cnt holds the number of edges taken since the fetch was accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      cnt      <= '0;
      weights  <= '0;
      w_valid  <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (32'(kernel_idx) < NUM_KERNELS) begin
              rom_addr <= base_calc;
              cnt      <= '0;
              busy     <= 1'b1;
              state    <= ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cnt < 4'd8) rom_addr <= rom_addr + 1'b1;
          if (cnt >= 4'd1) weights[32'(slot)*DW +: DW] <= rom_data;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd8) state <= DRAIN;
        end
        DRAIN: begin
          weights[8*DW +: DW] <= rom_data;
          w_valid             <= 1'b1;
          state               <= HOLD;
        end
        HOLD: begin
          if (w_ready) begin
            w_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_fetch.sv
// tb/tb_kernel_fetch.sv - directed bench for kernel_fetch with a 1-cycle registered ROM model
// ROM word[a] = a[7:0]; outputs are sampled 1 time unit after each rising edge.
module tb_kernel_fetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  kernel_idx;
  logic [8:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        busy;
  logic [71:0] weights;
  logic        w_valid;
  logic        w_ready;
  logic        err;

  logic [7:0]  rom_q;
  logic        noise_en;
  logic [7:0]  noise;

  int n_checks = 0;
  int n_fail   = 0;

  kernel_fetch #(.DW(8), .AW(9), .NUM_KERNELS(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .kernel_idx (kernel_idx),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy),
    .weights    (weights),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_addr[7:0];
  assign rom_data = noise_en ? noise : rom_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_w(input int base);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(base + k);
    return r;
  endfunction

  // Drives start for edge E0 and walks through E10, checking address and valid timing.
  task automatic fetch_to_valid(input int idx);
    int base;
    base       = idx * 9;
    start      = 1'b1;
    kernel_idx = 5'(idx);
    tick();
    start = 1'b0;
    check("e0_addr", 72'(rom_addr), 72'(base));
    check("e0_busy", 72'(busy), 72'(1));
    for (int j = 1; j <= 8; j++) begin
      tick();
      check("issue_addr", 72'(rom_addr), 72'(base + j));
      check("issue_valid", 72'(w_valid), 72'(0));
    end
    tick();
    check("e9_addr", 72'(rom_addr), 72'(base + 8));
    check("e9_valid", 72'(w_valid), 72'(0));
    tick();
    check("e10_valid", 72'(w_valid), 72'(1));
    check("e10_weights", weights, exp_w(base));
    check("e10_busy", 72'(busy), 72'(1));
  endtask

  initial begin
    logic [71:0] held;
    reset      = 1'b1;
    start      = 1'b0;
    kernel_idx = '0;
    w_ready    = 1'b0;
    noise_en   = 1'b0;
    noise      = '0;
    tick();
    tick();
    check("rst_addr", 72'(rom_addr), 72'(0));
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_valid", 72'(w_valid), 72'(0));
    check("rst_err", 72'(err), 72'(0));
    check("rst_weights", weights, 72'(0));
    reset = 1'b0;
    tick();

    // kernel 0, handshake after two stall cycles
    fetch_to_valid(0);
    tick();
    tick();
    check("k0_hold_valid", 72'(w_valid), 72'(1));
    w_ready = 1'b1;
    tick();
    w_ready = 1'b0;
    check("k0_hs_valid", 72'(w_valid), 72'(0));
    check("k0_hs_busy", 72'(busy), 72'(0));
    check("k0_keep_w", weights, exp_w(0));

    // kernel 23 with w_ready held high: w_valid lasts exactly one cycle
    w_ready = 1'b1;
    fetch_to_valid(23);
    tick();
    check("k23_e11_valid", 72'(w_valid), 72'(0));
    check("k23_e11_busy", 72'(busy), 72'(0));
    w_ready = 1'b0;

    // out-of-range kernel indices
    start      = 1'b1;
    kernel_idx = 5'd24;
    tick();
    start = 1'b0;
    check("oor_err", 72'(err), 72'(1));
    check("oor_busy", 72'(busy), 72'(0));
    check("oor_addr", 72'(rom_addr), 72'(215));
    tick();
    check("oor_err_pulse", 72'(err), 72'(0));
    check("oor_valid", 72'(w_valid), 72'(0));
    check("oor_weights", weights, exp_w(207));
    start      = 1'b1;
    kernel_idx = 5'd31;
    tick();
    start = 1'b0;
    check("oor31_err", 72'(err), 72'(1));
    check("oor31_busy", 72'(busy), 72'(0));
    tick();

    // long stall in HOLD with start pulses and a noisy ROM bus
    fetch_to_valid(5);
    held = exp_w(45);
    noise_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      noise      = 8'($urandom);
      start      = c[0];
      kernel_idx = 5'd7;
      tick();
      check("stall_valid", 72'(w_valid), 72'(1));
      check("stall_weights", weights, held);
      check("stall_err", 72'(err), 72'(0));
    end
    start    = 1'b0;
    noise_en = 1'b0;
    w_ready  = 1'b1;
    tick();
    w_ready = 1'b0;
    check("stall_hs_valid", 72'(w_valid), 72'(0));
    check("stall_hs_busy", 72'(busy), 72'(0));
    check("stall_addr", 72'(rom_addr), 72'(53));
    tick();

    // reset at E5 of a fetch, then restart on the first edge after reset
    start      = 1'b1;
    kernel_idx = 5'd1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 4; j++) tick();
    check("pre_rst_addr", 72'(rom_addr), 72'(13));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_addr", 72'(rom_addr), 72'(0));
    check("mid_rst_busy", 72'(busy), 72'(0));
    check("mid_rst_valid", 72'(w_valid), 72'(0));
    check("mid_rst_weights", weights, 72'(0));
    fetch_to_valid(2);

    // start on the handshake edge is ignored; one cycle later it is taken
    w_ready    = 1'b1;
    start      = 1'b1;
    kernel_idx = 5'd3;
    tick();
    w_ready = 1'b0;
    check("b2b_hs_busy", 72'(busy), 72'(0));
    check("b2b_hs_addr", 72'(rom_addr), 72'(26));
    fetch_to_valid(3);
    w_ready = 1'b1;
    tick();
    w_ready = 1'b0;
    check("b2b_end_valid", 72'(w_valid), 72'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/kernel_fetch.md
KERNEL_FETCH -- requirements
Module: kernel_fetch

Interface
REQ-001 Parameter DW, default 8: width of one weight word and of rom_data.
REQ-002 Parameter AW, default 9: width of rom_addr.
REQ-003 Parameter NUM_KERNELS, default 24: number of 3x3 kernels stored in the filter ROM, which holds 216 words.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: request to fetch one kernel; sampled only in IDLE.
REQ-007 Port kernel_idx, input, 5: kernel number, 0..NUM_KERNELS-1; sampled with start.
REQ-008 Port rom_addr, output, AW: registered address to the filter ROM.
REQ-009 Port rom_data, input, DW: ROM read data, valid one clock after the ROM samples rom_addr.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port weights, output, 9*DW: nine captured weights; weight k occupies bits [k*DW +: DW], with k=0 at the lowest address.
REQ-012 Port w_valid, output, 1: weights are complete and stable.
REQ-013 Port w_ready, input, 1: the downstream convolution unit accepts weights.
REQ-014 Port err, output, 1: one-cycle pulse flagging a rejected out-of-range kernel_idx.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, DRAIN and HOLD, with IDLE as the reset state.
REQ-016 In IDLE with start=1 and kernel_idx<NUM_KERNELS, at edge E0 the block SHALL latch base=kernel_idx*9, set rom_addr=base and cnt=0, and enter ISSUE.
REQ-017 In IDLE with start=1 and kernel_idx>=NUM_KERNELS, the block SHALL pulse err for one cycle, remain in IDLE, and leave rom_addr and weights unchanged.
REQ-018 In ISSUE, the block SHALL increment rom_addr by 1 per edge until it reaches base+8 (after E8), then hold rom_addr at base+8.
REQ-019 The capture pipeline SHALL account for the registered address plus the registered ROM: word k (address base+k) is written into weights slot k at edge E(k+2), for k=0..8.
REQ-020 ISSUE SHALL transition to DRAIN at E9; DRAIN SHALL capture the final word at E10 and enter HOLD.
REQ-021 w_valid SHALL rise at E10 and stay high in HOLD; weights SHALL not change while w_valid=1.
REQ-022 In HOLD, on an edge with w_ready=1, the block SHALL clear w_valid and return to IDLE; weights SHALL keep their last values.
REQ-023 Back-to-back fetch: start=1 on the same edge as the accepting handshake SHALL NOT be honored; start is sampled only once the FSM is in IDLE, so the minimum start-to-start spacing is 12 cycles.
REQ-024 start SHALL be ignored while busy=1; err SHALL NOT assert in that case.
REQ-025 w_ready while w_valid=0 SHALL have no effect.
REQ-026 Address arithmetic SHALL be unsigned; base+8 never exceeds 215, so rom_addr never wraps.

Reset
REQ-027 While reset=1 at a clock edge, the block SHALL force state=IDLE, rom_addr=0, cnt=0, weights=0, w_valid=0, err=0 and busy=0.
REQ-028 Reset asserted mid-fetch or in HOLD SHALL abort the operation with no partial w_valid, and the block SHALL accept start on the first edge after reset deasserts.

Verification
REQ-029 ROM model 1-cycle registered with word[a]=a[7:0]; start, kernel_idx=0 -> rom_addr 0..8 after E0..E8, w_valid at E10, weights slots = 0x00..0x08, busy high E0..handshake.
REQ-030 kernel_idx=23, w_ready held 1 -> weights slots 0xCF..0xD7, w_valid high exactly 1 cycle, IDLE at E11.
REQ-031 kernel_idx=24 with start -> err=1 for one cycle, busy stays 0, rom_addr unchanged, no w_valid.
REQ-032 w_ready=0 for 20 cycles in HOLD, with start pulses and rom_data toggling -> weights and w_valid stable; second start ignored; accepted at the first w_ready=1.
REQ-033 reset asserted at E5 of a fetch -> all outputs zero the next cycle; new start with kernel_idx=2 -> weights slots 0x12..0x1A, correct timing.
REQ-034 Start asserted on the handshake edge -> ignored; start one cycle later -> normal fetch with w_valid at E10 of the new fetch.
